// File: rtl/tmm_pkg.sv
// Shared state type and packing helpers for tiled_matrix_mult.
// The signed build (TILED_MATRIX_MULT_SIGNED_EN) uses the same types and widths.
package tmm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_B,
    READY,
    MAC,
    OUT
  } tmm_state_t;

  // Full-precision accumulator width: product bits plus log2(N) carry bits.
  function automatic int acc_width(input int width, input int n);
    return 2 * width + $clog2(n);
  endfunction

  // Rows are packed with element 0 in the least significant slot.
  function automatic int elem_lsb(input int idx, input int elem_width);
    return idx * elem_width;
  endfunction

  function automatic int elem_msb(input int idx, input int elem_width);
    return (idx + 1) * elem_width - 1;
  endfunction

endpackage

// File: rtl/tmm_mac_lane.sv
// One output column of the multiplier: multiply-accumulate with synchronous clear.
// TILED_MATRIX_MULT_SIGNED_EN selects two's-complement operands and sign extension.
module tmm_mac_lane
  import tmm_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 18
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 en,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [ACC_WIDTH-1:0] acc
);

  logic [2*WIDTH-1:0]   prod;
  logic [ACC_WIDTH-1:0] prod_ext;

`ifdef TILED_MATRIX_MULT_SIGNED_EN
  assign prod     = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign prod_ext = ACC_WIDTH'($signed(prod));
`else
  assign prod     = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign prod_ext = ACC_WIDTH'(prod);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/tiled_matrix_mult.sv
// Streaming C = A*B row multiplier with a resident N x N coefficient matrix B.
// Define TILED_MATRIX_MULT_SIGNED_EN for two's-complement operands and results.
module tiled_matrix_mult
  import tmm_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int N         = 4,
  parameter int ACC_WIDTH = acc_width(WIDTH, N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*WIDTH-1:0]     in_data,
  input  logic                   load_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*ACC_WIDTH-1:0] out_data,
  output logic                   b_loaded,
  output logic                   drop,
  output logic [2:0]             state_dbg
);

  // Handshake: a beat moves on a rising edge where valid && ready are both high.
  // in_ready and out_valid are registered and never depend on in_valid/out_ready.

  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  tmm_state_t           state;
  logic [CW-1:0]        row_cnt;
  logic [CW-1:0]        k;
  logic [WIDTH-1:0]     b_mem  [N][N];
  logic [WIDTH-1:0]     a_row  [N];
  logic [WIDTH-1:0]     in_row [N];
  logic [ACC_WIDTH-1:0] acc    [N];
  logic                 lane_clear;
  logic                 lane_en;

  assign state_dbg = state;

  // Accumulators sit at zero while waiting for an A row, so the accept edge needs no clear pulse.
  assign lane_clear = (state == READY);
  assign lane_en    = (state == MAC);

  for (genvar j = 0; j < N; j++) begin : g_unpack
    assign in_row[j] = in_data[elem_msb(j, WIDTH):elem_lsb(j, WIDTH)];
  end

  for (genvar j = 0; j < N; j++) begin : g_lane
    tmm_mac_lane #(
      .WIDTH    (WIDTH),
      .ACC_WIDTH(ACC_WIDTH)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .clear(lane_clear),
      .en   (lane_en),
      .a    (a_row[k]),
      .b    (b_mem[k][j]),
      .acc  (acc[j])
    );
    assign out_data[elem_msb(j, ACC_WIDTH):elem_lsb(j, ACC_WIDTH)] = acc[j];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      row_cnt   <= '0;
      k         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      b_loaded  <= 1'b0;
      drop      <= 1'b0;
      for (int r = 0; r < N; r++) begin
        a_row[r] <= '0;
        for (int c = 0; c < N; c++) begin
          b_mem[r][c] <= '0;
        end
      end
    end else begin
      drop <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (load_b) begin
              b_mem[0] <= in_row;
              row_cnt  <= CW'(1);
              state    <= LOAD_B;
            end else begin
              drop <= 1'b1;
            end
          end
        end
        LOAD_B: begin
          // load_b is ignored here: the next N-1 beats are B rows regardless.
          if (in_valid) begin
            b_mem[row_cnt] <= in_row;
            if (row_cnt == LAST) begin
              row_cnt  <= '0;
              b_loaded <= 1'b1;
              state    <= READY;
            end else begin
              row_cnt <= row_cnt + CW'(1);
            end
          end
        end
        READY: begin
          if (in_valid) begin
            if (load_b) begin
              b_loaded <= 1'b0;
              b_mem[0] <= in_row;
              row_cnt  <= CW'(1);
              state    <= LOAD_B;
            end else begin
              a_row    <= in_row;
              k        <= '0;
              in_ready <= 1'b0;
              state    <= MAC;
            end
          end
        end
        MAC: begin
          if (k == LAST) begin
            k         <= '0;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            k <= k + CW'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= READY;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
